argmax_13_32: RTL and testbench
===============================

ARGMAX_13_32 -- requirements
Module: argmax_13_32

Interface
REQ-001 Parameters SHALL be: N, 13, number of elements per input vector; T, 32, element width in bits.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high.
REQ-004 Port s_valid SHALL be: input, 1 bit, upstream element valid.
REQ-005 Port s_ready SHALL be: output, 1 bit, block can accept an element.
REQ-006 Port data_in SHALL be: input, T bits, signed element from the upstream layer, streamed in index order 0..N-1.
REQ-007 Port m_valid SHALL be: output, 1 bit, result valid.
REQ-008 Port m_ready SHALL be: input, 1 bit, downstream accepts the result.
REQ-009 Port idx_out SHALL be: output, 4 bits, index of the maximum element.
REQ-010 Port max_out SHALL be: output, T bits, signed value of the maximum element.

Function
REQ-011 States SHALL be COLLECT and OUTPUT only; reset state is COLLECT.
REQ-012 s_ready SHALL equal 1 exactly when state is COLLECT and reset is low; it is combinational from registered state.
REQ-013 An element SHALL be accepted on a rising edge where s_valid and s_ready are both 1; no other edge changes the element counter.
REQ-014 Element counter cnt (0..N-1) SHALL increment per accept and clear to 0 on the accept where cnt equals N-1.
REQ-015 On the accept with cnt=0, max_out SHALL load data_in and idx_out SHALL load 0 unconditionally.
REQ-016 On an accept with cnt>0, max_out/idx_out SHALL load data_in/cnt only if data_in > max_out under signed comparison.
REQ-017 Ties SHALL keep the earlier (lower) index.
REQ-018 On the accept with cnt=N-1, the comparison SHALL still apply, the state SHALL move to OUTPUT, and m_valid SHALL be 1 in the following cycle.
REQ-019 Latency from the last element accept edge to m_valid high SHALL be one cycle.
REQ-020 In OUTPUT, m_valid SHALL stay 1 and idx_out/max_out SHALL stay constant until m_valid and m_ready are both 1 on an edge.
REQ-021 On that handshake edge, the state SHALL return to COLLECT, so m_valid=0 and s_ready=1 in the next cycle.
REQ-022 The block SHALL NOT accept a new element in the same cycle as the result handshake.
REQ-023 m_ready while m_valid=0, and s_valid while s_ready=0, SHALL be ignored.
REQ-024 Gaps in s_valid mid-vector SHALL stall cnt and hold the partial max with no loss.
REQ-025 All elements negative SHALL still yield the signed maximum; no ReLU or saturation is applied here.

Reset
REQ-026 On an edge with reset=1: state=COLLECT, cnt=0, m_valid=0, idx_out=0, max_out=0.
REQ-027 Reset SHALL override every other event in the same cycle, including mid-vector or during OUTPUT; a partial vector is discarded.
REQ-028 s_ready SHALL be 0 while reset is high and 1 in the first cycle after reset is released.

Structure
REQ-029 Shared package nn_pkg SHALL hold T, N, and the state enum {COLLECT, OUTPUT}, and is reused by the layer blocks.
REQ-030 The block SHALL be a single module with no sub-module; comparator, counter and FSM are inline.

Verification
REQ-031 Elements 5,9,3,9,1,0,0,0,0,0,0,0,2 streamed back-to-back with m_ready=1 -> m_valid one cycle after the 13th accept, idx_out=1, max_out=9 (tie rule).
REQ-032 All elements -100 except index 12 = -7 -> idx_out=12, max_out=-7 (signed compare, last-element update).
REQ-033 Result pending with m_ready=0 for 10 cycles and s_valid=1 throughout -> s_ready=0, outputs stable, no element consumed; m_ready=1 -> next cycle s_ready=1, m_valid=0.
REQ-034 s_valid toggled randomly during the vector 0..12 with value = index -> idx_out=12, max_out=12, cnt advances only on handshakes.
REQ-035 Reset asserted after 6 accepts, then a full vector with maximum 40 at index 3 -> idx_out=3, max_out=40; no carry-over from the aborted vector.
REQ-036 Three consecutive vectors with m_ready held 1 -> three results in order, each m_valid pulse exactly one cycle wide.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the classifier layer blocks: vector geometry and
// the two-state collect/emit handshake used by the streaming reducers.
package nn_pkg;

    localparam int N     = 13;
    localparam int T     = 32;
    localparam int IDX_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

endpackage

// File: rtl/argmax_13_32.sv
// Streaming argmax: consumes N signed elements in index order, then holds
// the index and value of the maximum until the downstream accepts it.
module argmax_13_32
    import nn_pkg::*;
#(
    parameter int N = nn_pkg::N,
    parameter int T = nn_pkg::T
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [T-1:0]  data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [IDX_W-1:0]     idx_out,
    output logic signed [T-1:0]  max_out
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic signed [T-1:0]   max_q, max_d;
    logic                  m_valid_q, m_valid_d;
    logic                  accept;

    // Strict greater-than keeps the earlier index on ties.
    function automatic logic is_greater(input logic signed [T-1:0] a,
                                        input logic signed [T-1:0] b);
        return a > b;
    endfunction

    assign s_ready = (state_q == COLLECT) && !reset;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        max_d     = max_q;
        m_valid_d = m_valid_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if ((cnt_q == '0) || is_greater(data_in, max_q)) begin
                        max_d = data_in;
                        idx_d = cnt_q;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d     = '0;
                        state_d   = OUTPUT;
                        m_valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUTPUT: begin
                // Result is frozen until the downstream takes it.
                if (m_valid_q && m_ready) begin
                    state_d   = COLLECT;
                    m_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_valid = m_valid_q;
    assign idx_out = idx_q;
    assign max_out = max_q;

endmodule

// File: tb/tb_argmax_13_32.sv
// Scoreboard bench for argmax_13_32: driver pushes reference results,
// monitor pops and compares at every output handshake.
module tb_argmax_13_32;

    localparam int N = 13;
    localparam int T = 32;

    typedef struct {
        logic [3:0]          idx;
        logic signed [T-1:0] mx;
    } res_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                s_valid;
    logic                s_ready;
    logic signed [T-1:0] data_in;
    logic                m_valid;
    logic                m_ready;
    logic [3:0]          idx_out;
    logic signed [T-1:0] max_out;

    int   checks = 0;
    int   passed = 0;
    res_t exp_q[$];
    logic signed [T-1:0] vec [N];
    bit   mr_rand  = 1'b0;
    bit   mr_level = 1'b1;

    argmax_13_32 dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .data_in (data_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .idx_out (idx_out),
        .max_out (max_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: first index holding the largest signed value.
    function automatic res_t ref_argmax();
        res_t r;
        r.idx = 0;
        r.mx  = vec[0];
        for (int i = 1; i < N; i++)
            if (vec[i] > r.mx) begin
                r.mx  = vec[i];
                r.idx = 4'(i);
            end
        return r;
    endfunction

    // m_ready owner: changes only just after a rising edge.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_level;
        end
    end

    // Monitor: compares every result taken, plus hold-stability and pulse width.
    bit                  hs_prev = 1'b0;
    bit                  pend_seen = 1'b0;
    logic [3:0]          pend_idx;
    logic signed [T-1:0] pend_max;
    always @(negedge clk) begin
        if (reset) begin
            hs_prev   = 1'b0;
            pend_seen = 1'b0;
        end else begin
            if (hs_prev) chk("m_valid_pulse_width", m_valid, 0);
            if (pend_seen && m_valid) begin
                chk("hold_idx_stable", idx_out, pend_idx);
                chk("hold_max_stable", max_out, pend_max);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("result_idx", idx_out, e.idx);
                    chk("result_max", max_out, e.mx);
                end
                hs_prev   = 1'b1;
                pend_seen = 1'b0;
            end else begin
                hs_prev   = 1'b0;
                pend_seen = m_valid;
                pend_idx  = idx_out;
                pend_max  = max_out;
            end
        end
    end

    task automatic send_elems(input int n_elems, input int gap_pct, input bit push);
        if (push) exp_q.push_back(ref_argmax());
        for (int i = 0; i < n_elems; i++) begin
            bit acc = 1'b0;
            int waited = 0;
            while (!acc) begin
                @(negedge clk);
                s_valid = ($urandom_range(0, 99) >= gap_pct);
                data_in = s_valid ? vec[i] : $signed($urandom);
                acc = s_valid && s_ready;
                waited++;
                if (waited > 500) begin
                    chk("accept_timeout", 0, 1);
                    s_valid = 1'b0;
                    return;
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (push && n_elems == N) chk("latency_m_valid", m_valid, 1);
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (exp_q.size() != 0 || m_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 500) begin
                chk("drain_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_idx", idx_out, 0);
        chk("reset_max", max_out, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_s_ready", s_ready, 1);

        // Tie keeps the lower index.
        vec = '{5, 9, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2};
        send_elems(N, 0, 1);
        wait_idle();

        // All negative, maximum only at the last element.
        for (int i = 0; i < N; i++) vec[i] = -100;
        vec[12] = -7;
        send_elems(N, 0, 1);
        wait_idle();

        // Back-pressure: result held, elements refused.
        mr_level = 1'b0;
        for (int i = 0; i < N; i++) vec[i] = $signed($urandom);
        send_elems(N, 0, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            data_in = $signed($urandom);
            #1;
            chk("bp_s_ready", s_ready, 0);
            chk("bp_m_valid", m_valid, 1);
            chk("bp_idx", idx_out, exp_q[0].idx);
            chk("bp_max", max_out, exp_q[0].mx);
        end
        @(negedge clk);
        s_valid  = 1'b0;
        mr_level = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("release_m_valid", m_valid, 0);
        chk("release_s_ready", s_ready, 1);
        wait_idle();

        // Ascending values with random s_valid gaps.
        for (int i = 0; i < N; i++) vec[i] = i;
        send_elems(N, 50, 1);
        wait_idle();

        // Abort a partial vector with reset; big values must not survive.
        for (int i = 0; i < N; i++) vec[i] = 1000;
        send_elems(6, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_s_ready_in_reset", s_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_idx", idx_out, 0);
        chk("abort_max", max_out, 0);
        reset = 1'b0;
        #1;
        chk("abort_s_ready_after", s_ready, 1);
        for (int i = 0; i < N; i++) vec[i] = $signed($urandom_range(0, 89)) - 50;
        vec[3] = 40;
        send_elems(N, 0, 1);
        wait_idle();

        // Three vectors back to back with m_ready held high.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N; i++) vec[i] = $signed($urandom_range(0, 15)) - 8;
            send_elems(N, 0, 1);
        end
        wait_idle();

        // Randomized values, gaps and downstream back-pressure.
        mr_rand = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++)
                vec[i] = (v % 2 == 0) ? $signed($urandom) : $signed($urandom_range(0, 7)) - 4;
            send_elems(N, 30, 1);
        end
        mr_rand  = 1'b0;
        mr_level = 1'b1;
        wait_idle();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
